// File: rtl/ffo_pkg.sv
// -----------------------------------------------------------------------------
// ffo_pkg
// Shared definitions for the find-first-one enumerator: the controller state
// type and the encoding of the scan-direction input.
// -----------------------------------------------------------------------------
package ffo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Encoding of the dir input: scan from index 0 upward, or from N-1 downward.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : ffo_pkg

// File: rtl/ffo_chunk.sv
// -----------------------------------------------------------------------------
// ffo_chunk
// Combinational priority encoder over one K-bit chunk. Bit j of the chunk is
// scan offset j, so the lowest set bit wins.
//
// Ports:
//   chunk   in   K bits, bit j = scan offset j within the chunk
//   any     out  at least one bit of the chunk is set
//   offset  out  offset of the first set bit (0 when any=0)
// -----------------------------------------------------------------------------
module ffo_chunk #(
    parameter int K  = 4,
    parameter int OW = (K > 1) ? $clog2(K) : 1
) (
    input  logic [K-1:0]  chunk,
    output logic          any,
    output logic [OW-1:0] offset
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        any    = |chunk;
        offset = '0;
        // Walk from the top down so the lowest set offset is the last writer.
        for (int j = K - 1; j >= 0; j--) begin
            if (chunk[j]) begin
                offset = OW'(j);
            end
        end
    end

endmodule : ffo_chunk

// File: rtl/ffo_enum.sv
// -----------------------------------------------------------------------------
// ffo_enum
// Finds the first set bit of an N-bit vector, or enumerates every set bit,
// scanning K bits per clock in either direction with a ready/valid-ack
// handshake on each reported position.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request, sampled only while ready=1
//   b          in   vector [0:N-1], index 0 leftmost, sampled with start
//   dir        in   0 = scan index 0 upward, 1 = index N-1 downward
//   all        in   0 = report first set bit, 1 = report every set bit
//   out_ack    in   consumer accepts the current position (EMIT only)
//   out_valid  out  p holds a valid set-bit position
//   p          out  index of the reported bit in b numbering
//   v          out  at least one set bit found in the last completed operation
//   count      out  positions accepted in the last or current operation
//   ready      out  idle, accepts start
// -----------------------------------------------------------------------------
module ffo_enum
    import ffo_pkg::*;
#(
    parameter int N = 32,
    parameter int K = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [0:N-1]           b,
    input  logic                   dir,
    input  logic                   all,
    input  logic                   out_ack,
    output logic                   out_valid,
    output logic [$clog2(N)-1:0]   p,
    output logic                   v,
    output logic [$clog2(N+1)-1:0] count,
    output logic                   ready
);

    localparam int PW     = $clog2(N);
    localparam int CNW    = $clog2(N + 1);
    localparam int NCHUNK = N / K;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int KW     = $clog2(K);
    localparam int OW     = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    state_t        state;
    logic [0:N-1]  shadow;
    logic          dir_r;
    logic          all_r;
    logic [CW-1:0] cursor;

    // Scan position of offset 0 in the current chunk.
    logic [PW-1:0] base;
    logic [K-1:0]  chunk_fwd;
    logic [K-1:0]  chunk_rev;
    logic [K-1:0]  chunk;
    logic          chunk_any;
    logic [OW-1:0] chunk_off;
    logic [PW-1:0] scan_pos;
    logic [PW-1:0] hit_idx;

    // Because N is a power of two, N-1-q is just the bitwise inverse of q, so
    // the downward scan reads the mirrored slice and feeds the same encoder.
    always_comb begin
        base      = PW'(cursor) << KW;
        chunk_fwd = '0;
        chunk_rev = '0;
        for (int j = 0; j < K; j++) begin
            chunk_fwd[j] = shadow[base + PW'(j)];
            chunk_rev[j] = shadow[~(base + PW'(j))];
        end
        chunk = (dir_r == DIR_DOWN) ? chunk_rev : chunk_fwd;
    end

    ffo_chunk #(
        .K  (K),
        .OW (OW)
    ) u_chunk (
        .chunk  (chunk),
        .any    (chunk_any),
        .offset (chunk_off)
    );

    assign scan_pos = base + PW'(chunk_off);
    assign hit_idx  = (dir_r == DIR_DOWN) ? ~scan_pos : scan_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow vector is ordinary flops, so it is cleared with the rest of the state.
            state  <= IDLE;
            shadow <= '0;
            dir_r  <= DIR_UP;
            all_r  <= 1'b0;
            cursor <= '0;
            p      <= '0;
            v      <= 1'b0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            unique case (state)
                IDLE: begin
                    // out_ack is not looked at here, so start always wins.
                    if (start) begin
                        shadow <= b;
                        dir_r  <= dir;
                        all_r  <= all;
                        cursor <= '0;
                        count  <= '0;
                        v      <= 1'b0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (chunk_any) begin
                        p               <= hit_idx;
                        shadow[hit_idx] <= 1'b0;
                        state           <= EMIT;
                    end else if (cursor == LAST_CHUNK) begin
                        v     <= (count != '0);
                        state <= IDLE;
                    end else begin
                        cursor <= cursor + CW'(1);
                    end
                end
                EMIT: begin
                    if (out_ack) begin
                        count <= count + CNW'(1);
                        if (all_r) begin
                            // Re-scan the same chunk: further set bits may remain in it.
                            state <= SCAN;
                        end else begin
                            v     <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready     = (state == IDLE);
    assign out_valid = (state == EMIT);

endmodule : ffo_enum

// File: tb/tb_ffo_enum.sv
// -----------------------------------------------------------------------------
// tb_ffo_enum
// Directed self-checking bench for ffo_enum with N=32, K=4.
// -----------------------------------------------------------------------------
module tb_ffo_enum;

    localparam int N = 32;
    localparam int K = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [0:N-1]  b;
    logic          dir;
    logic          all;
    logic          out_ack;
    logic          out_valid;
    logic [4:0]    p;
    logic          v;
    logic [5:0]    count;
    logic          ready;

    int n_cmp;
    int n_fail;

    ffo_enum #(
        .N (N),
        .K (K)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .b         (b),
        .dir       (dir),
        .all       (all),
        .out_ack   (out_ack),
        .out_valid (out_valid),
        .p         (p),
        .v         (v),
        .count     (count),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request at a falling edge; returns 1 ns after the start edge.
    task automatic do_start(input logic [0:N-1] vec, input logic d, input logic a);
        @(negedge clk);
        b     = vec;
        dir   = d;
        all   = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts rising edges until out_valid appears; -1 if the operation ends
    // without one or the budget runs out.
    task automatic wait_valid(output int edges);
        edges = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                edges = i;
                return;
            end
            if (ready) return;
        end
    endtask

    // Single accept pulse from 1 ns after an edge to 1 ns after the next.
    task automatic ack_once();
        out_ack = 1'b1;
        @(posedge clk);
        #1;
        out_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({ready, out_valid, p, v, count} !== {1'b1, 1'b0, 5'd0, 1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b out_valid=%b p=%0d v=%b count=%0d, want 1 0 0 0 0",
                     ready, out_valid, p, v, count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_empty();
        int  edges;
        bit  seen_valid;
        edges      = -1;
        seen_valid = 0;
        do_start('0, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1;
            if (ready) begin
                edges = i;
                break;
            end
        end
        n_cmp++;
        if (edges !== 8) begin
            n_fail++;
            $display("FAIL empty_latency: ready after %0d edges, want 8", edges);
        end
        n_cmp++;
        if (seen_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_no_valid: out_valid seen=%b, want 0", seen_valid);
        end
        n_cmp++;
        if ({v, count} !== {1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL empty_result: v=%b count=%0d, want v=0 count=0", v, count);
        end
    endtask

    task automatic test_last_bit_up();
        int edges;
        do_start(32'h0000_0001, 1'b0, 1'b0);
        // Inputs changed after the start edge must not matter.
        b   = '1;
        dir = 1'b1;
        wait_valid(edges);
        n_cmp++;
        if (edges !== 8 || p !== 5'd31) begin
            n_fail++;
            $display("FAIL last_bit_up: valid at edge %0d p=%0d, want edge 8 p=31", edges, p);
        end
        ack_once();
        n_cmp++;
        if ({ready, out_valid, v, count} !== {1'b1, 1'b0, 1'b1, 6'd1}) begin
            n_fail++;
            $display("FAIL last_bit_up_done: ready=%b out_valid=%b v=%b count=%0d, want 1 0 1 1",
                     ready, out_valid, v, count);
        end
    endtask

    task automatic test_last_bit_down();
        int edges;
        do_start(32'h0000_0001, 1'b1, 1'b0);
        wait_valid(edges);
        n_cmp++;
        if (edges !== 1 || p !== 5'd31) begin
            n_fail++;
            $display("FAIL last_bit_down: valid at edge %0d p=%0d, want edge 1 p=31", edges, p);
        end
        ack_once();
        n_cmp++;
        if ({ready, v, count} !== {1'b1, 1'b1, 6'd1}) begin
            n_fail++;
            $display("FAIL last_bit_down_done: ready=%b v=%b count=%0d, want 1 1 1", ready, v, count);
        end
        // Result registers hold while idle.
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ready, p, v, count} !== {1'b1, 5'd31, 1'b1, 6'd1}) begin
            n_fail++;
            $display("FAIL idle_hold: ready=%b p=%0d v=%b count=%0d, want 1 31 1 1", ready, p, v, count);
        end
    endtask

    // Enumerate with out_ack held high; positions collected in order.
    task automatic run_enum(input logic [0:N-1] vec, input logic d,
                            output int seq[$], output int first_edge);
        seq        = {};
        first_edge = -1;
        @(negedge clk);
        out_ack = 1'b1;
        do_start(vec, d, 1'b1);
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (first_edge < 0) first_edge = i;
                seq.push_back(int'(p));
            end
            if (ready) break;
        end
        out_ack = 1'b0;
    endtask

    task automatic test_enum_all();
        int seq[$];
        int fe;
        b = '0;
        b[0]  = 1'b1;
        b[5]  = 1'b1;
        b[31] = 1'b1;
        run_enum(b, 1'b0, seq, fe);
        n_cmp++;
        if (seq.size() != 3 || seq[0] != 0 || seq[1] != 5 || seq[2] != 31) begin
            n_fail++;
            $display("FAIL enum_up_seq: got %p, want '{0, 5, 31}", seq);
        end
        n_cmp++;
        if ({ready, v, count} !== {1'b1, 1'b1, 6'd3}) begin
            n_fail++;
            $display("FAIL enum_up_done: ready=%b v=%b count=%0d, want 1 1 3", ready, v, count);
        end
    endtask

    // Start with out_ack already high in IDLE: the start must still be taken.
    task automatic test_back_to_back();
        logic [0:N-1] vec;
        int seq[$];
        int fe;
        vec    = '0;
        vec[1] = 1'b1;
        vec[2] = 1'b1;
        run_enum(vec, 1'b1, seq, fe);
        n_cmp++;
        if (fe != 8 || seq.size() != 2 || seq[0] != 2 || seq[1] != 1) begin
            n_fail++;
            $display("FAIL enum_down_seq: first at edge %0d seq %p, want edge 8 '{2, 1}", fe, seq);
        end
        n_cmp++;
        if ({ready, v, count} !== {1'b1, 1'b1, 6'd2}) begin
            n_fail++;
            $display("FAIL enum_down_done: ready=%b v=%b count=%0d, want 1 1 2", ready, v, count);
        end
    endtask

    task automatic test_backpressure();
        logic [0:N-1] vec;
        int  edges;
        bit  stable;
        vec     = '0;
        vec[20] = 1'b1;
        do_start(vec, 1'b0, 1'b0);
        // Stray accept and a competing request during SCAN.
        b       = '1;
        out_ack = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        out_ack = 1'b0;
        start   = 1'b0;
        wait_valid(edges);
        if (edges > 0) edges = edges + 1;
        n_cmp++;
        if (edges !== 6 || p !== 5'd20) begin
            n_fail++;
            $display("FAIL bp_first: valid at edge %0d p=%0d, want edge 6 p=20", edges, p);
        end
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || p !== 5'd20 || count !== 6'd0) stable = 0;
        end
        n_cmp++;
        if (stable !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: out_valid=%b p=%0d count=%0d after stall, want held 1 20 0",
                     out_valid, p, count);
        end
        ack_once();
        n_cmp++;
        if ({ready, v, count} !== {1'b1, 1'b1, 6'd1}) begin
            n_fail++;
            $display("FAIL bp_done: ready=%b v=%b count=%0d, want 1 1 1", ready, v, count);
        end
    endtask

    task automatic test_reset_mid();
        logic [0:N-1] vec;
        int edges;
        vec    = '0;
        vec[9] = 1'b1;
        do_start(vec, 1'b0, 1'b0);
        wait_valid(edges);
        n_cmp++;
        if (edges !== 3 || p !== 5'd9) begin
            n_fail++;
            $display("FAIL pre_reset_emit: valid at edge %0d p=%0d, want edge 3 p=9", edges, p);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ready, out_valid, p, v, count} !== {1'b1, 1'b0, 5'd0, 1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL mid_reset: got ready=%b out_valid=%b p=%0d v=%b count=%0d, want 1 0 0 0 0",
                     ready, out_valid, p, v, count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        vec     = '0;
        vec[12] = 1'b1;
        do_start(vec, 1'b0, 1'b0);
        wait_valid(edges);
        n_cmp++;
        if (edges !== 4 || p !== 5'd12) begin
            n_fail++;
            $display("FAIL post_reset: valid at edge %0d p=%0d, want edge 4 p=12", edges, p);
        end
        ack_once();
        n_cmp++;
        if ({ready, v, count} !== {1'b1, 1'b1, 6'd1}) begin
            n_fail++;
            $display("FAIL post_reset_done: ready=%b v=%b count=%0d, want 1 1 1", ready, v, count);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        start   = 1'b0;
        b       = '0;
        dir     = 1'b0;
        all     = 1'b0;
        out_ack = 1'b0;

        test_reset();
        test_empty();
        test_last_bit_up();
        test_last_bit_down();
        test_enum_all();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_ffo_enum

// File: doc/ffo_enum.md
FFO_ENUM -- requirements
Module: ffo_enum

Interface
REQ-001 Parameter N, default 32, vector width; SHALL be a power of 2, N >= 4.
REQ-002 Parameter K, default 4, bits examined per scan cycle; SHALL be a power of 2 with 1 <= K <= N.
REQ-003 clock  input  1  single rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled only when ready=1.
REQ-006 b  input  N  vector [0:N-1], index 0 leftmost; sampled with start.
REQ-007 dir  input  1  0 = scan index 0 upward, 1 = index N-1 downward; sampled with start.
REQ-008 all  input  1  0 = report first set bit only, 1 = enumerate every set bit; sampled with start.
REQ-009 out_ack  input  1  consumer accepts the current position.
REQ-010 out_valid  output  1  p holds a valid set-bit position.
REQ-011 p  output  $clog2(N)  index of the reported bit in b numbering.
REQ-012 v  output  1  at least one set bit found in the last completed operation.
REQ-013 count  output  $clog2(N+1)  positions accepted in the last or current operation.
REQ-014 ready  output  1  idle; accepts start.

Function
REQ-015 States: IDLE, SCAN, EMIT; ready=1 iff IDLE, out_valid=1 iff EMIT; all outputs registered or state-decoded.
REQ-016 IDLE, start=1: latch b, dir and all into a shadow register; chunk cursor=0, count=0, v=0; go to SCAN.
REQ-017 Scan order position q maps to index q when dir=0 and to index N-1-q when dir=1.
REQ-018 SCAN examines one K-bit chunk per cycle: scan positions cursor*K to cursor*K+K-1.
REQ-019 SCAN, chunk has a set bit: load p with the first set bit in scan order; clear that bit in the shadow; go to EMIT.
REQ-020 SCAN, chunk empty and not the last chunk: increment cursor, stay in SCAN.
REQ-021 SCAN, last chunk (N/K-1) empty: set v = (count != 0); go to IDLE.
REQ-022 EMIT holds out_valid=1 and a stable p until out_ack=1 is sampled at a rising edge (backpressure).
REQ-023 EMIT, accepted: count+1; if all=0, set v=1 and go to IDLE; if all=1, go to SCAN at the same cursor.
REQ-024 Latency: first set bit in chunk c sets out_valid at the (c+1)th rising edge after the start edge; an empty vector sets ready at the (N/K)th edge.
REQ-025 out_ack outside EMIT SHALL be ignored; start outside IDLE SHALL be ignored; b, dir and all changes after the start edge SHALL have no effect.
REQ-026 start and out_ack sampled high at the same edge in IDLE: only start takes effect.
REQ-027 v, count and p SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-028 reset=0 SHALL force IDLE immediately, independent of clock: ready=1, out_valid=0, p=0, v=0, count=0, shadow=0, cursor=0.
REQ-029 Reset during SCAN or EMIT SHALL abandon the operation; the first edge after release SHALL accept start.

Structure
REQ-030 Shared package ffo_pkg SHALL hold the state typedef (IDLE, SCAN, EMIT) and the dir encoding constants.
REQ-031 Combinational sub-module ffo_chunk (parameter K) SHALL return any-set and the offset of the first set bit within the chunk; instantiated once.
REQ-032 Dir handling SHALL use a reversal of the chunk slice, not a second encoder.

Verification (N=32, K=4)
REQ-033 b=0, all=0, start -> no out_valid; ready at the 8th edge after start; v=0, count=0.
REQ-034 b=32'h00000001 (only b[31] set), dir=0, all=0 -> out_valid at the 8th edge, p=31; ack -> ready, v=1, count=1.
REQ-035 Same b, dir=1 -> out_valid at the 1st edge, p=31.
REQ-036 b[0], b[5] and b[31] set, dir=0, all=1, out_ack held 1 -> p sequence 0, 5, 31; then ready, v=1, count=3.
REQ-037 Backpressure: out_ack held 0 for 10 cycles in EMIT -> out_valid and p stable; stray out_ack and start pulses in SCAN are ignored.
REQ-038 reset=0 pulsed mid-EMIT -> outputs at the REQ-028 values immediately; a new start after release runs correctly.
